tx_feeder: RTL and testbench

TX_FEEDER -- requirements
Module: tx_feeder

---
 rtl/tx_pkg.sv | 14 +
 rtl/tx_fifo.sv | 61 ++++++
 rtl/tx_feeder.sv | 121 ++++++++++++
 tb/tb_tx_feeder.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and widths for the tx_feeder transmit path.
package tx_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY,
    DONE
  } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO with registered level/full/empty.
// A write at full is accepted only when a pop happens in the same cycle.
module tx_fifo
  import tx_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              tx_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_full;
  logic              r_empty;

  logic              w_wr;
  logic              w_rd;
  logic [LW-1:0]     w_level_nx;

  assign w_rd       = rd_en && !r_empty;
  assign w_wr       = wr_en && (!r_full || w_rd);
  assign w_level_nx = r_level + LW'(w_wr) - LW'(w_rd);

  always_ff @(posedge tx_clk) begin
    if (w_wr) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nx;
      r_full  <= (w_level_nx == LW'(DEPTH));
      r_empty <= (w_level_nx == '0);
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign level   = r_level;

endmodule

// File: rtl/tx_feeder.sv
// FIFO-fed handshake to a serial transmitter; counts sent bytes.
// Define TX_FEEDER_WDOG_EN to add the REQ watchdog and wdog_err.
module tx_feeder
  import tx_pkg::*;
#(
  parameter  int DEPTH       = 16,
  parameter  int WDOG_CYCLES = 16,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic              tx_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic [CNT_W-1:0]  bytes_sent
`ifdef TX_FEEDER_WDOG_EN
  ,
  output logic              wdog_err
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tx_feeder: DEPTH must be a power of 2, at least 2");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("tx_feeder: WDOG_CYCLES must be at least 1");
  end

  tx_state_t         r_state;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_start;
  logic [CNT_W-1:0]  r_bytes_sent;

  logic              w_pop;
  logic              w_empty;
  logic [BYTE_W-1:0] w_head;

`ifdef TX_FEEDER_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0]     r_wdog;
  logic              r_wdog_err;
  assign wdog_err = r_wdog_err;
`endif

  assign w_pop = (r_state == IDLE) && !w_empty && tx_ready;

  tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .tx_clk  (tx_clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (full),
    .empty   (w_empty),
    .level   (level)
  );

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_bytes_sent <= '0;
`ifdef TX_FEEDER_WDOG_EN
      r_wdog       <= '0;
      r_wdog_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_state    <= REQ;
`ifdef TX_FEEDER_WDOG_EN
            r_wdog     <= '0;
`endif
          end
        end
        REQ: begin
          if (!tx_ready) begin
            r_tx_start <= 1'b0;
            r_state    <= BUSY;
          end
`ifdef TX_FEEDER_WDOG_EN
          // Transmitter never took the byte: drop it uncounted.
          else if (r_wdog == WW'(WDOG_CYCLES - 1)) begin
            r_tx_start <= 1'b0;
            r_wdog_err <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_wdog <= r_wdog + WW'(1);
          end
`endif
        end
        BUSY: begin
          if (tx_ready) r_state <= DONE;
        end
        DONE: begin
          r_bytes_sent <= r_bytes_sent + CNT_W'(1);
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign empty      = w_empty;
  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_tx_feeder.sv
// Self-checking bench for tx_feeder: directed scenarios plus a
// randomized run scored against a queue model of the byte stream.
module tb_tx_feeder;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          tx_clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_ready;
  logic [15:0]   bytes_sent;
`ifdef TX_FEEDER_WDOG_EN
  logic          wdog_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tx_clk = ~tx_clk;

  tx_feeder #(
    .DEPTH       (DEPTH),
    .WDOG_CYCLES (16)
  ) dut (
    .tx_clk     (tx_clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .bytes_sent (bytes_sent)
`ifdef TX_FEEDER_WDOG_EN
    ,
    .wdog_err   (wdog_err)
`endif
  );

  task automatic do_reset();
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (2) @(negedge tx_clk);
    reset = 1'b0;
    @(negedge tx_clk);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge tx_clk);
    wr_en   = 1'b0;
  endtask

  // Transmitter model: accept one start request and complete it.
  task automatic serve_one(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    tx_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge tx_clk);
    end
    if (ok) begin
      b = tx_data;
      tx_ready = 1'b0;
      @(negedge tx_clk);
      tx_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_ready = 1'b0;
    repeat (2) @(negedge tx_clk);
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({tx_start, tx_data, empty, full, level, bytes_sent} !==
        {1'b0, 8'h00, 1'b1, 1'b0, LW'(0), 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_outputs: start=%b data=%h empty=%b full=%b level=%0d sent=%0d",
               tx_start, tx_data, empty, full, level, bytes_sent);
    end
`ifdef TX_FEEDER_WDOG_EN
    n_tests++;
    if (wdog_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wdog: got %b want 0", wdog_err);
    end
`endif
    repeat (2) @(negedge tx_clk);
    reset = 1'b0;
    @(negedge tx_clk);
  endtask

  task automatic test_single();
    do_reset();
    tx_ready = 1'b1;
    wr_byte(8'hA5);
    @(negedge tx_clk);
    n_tests++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_start: start=%b data=%h want 1/a5", tx_start, tx_data);
    end
    tx_ready = 1'b0;
    @(negedge tx_clk);
    n_tests++;
    if (tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: start=%b want 0", tx_start);
    end
    tx_ready = 1'b1;
    repeat (3) @(negedge tx_clk);
    n_tests++;
    if (bytes_sent !== 16'd1 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_count: sent=%0d data=%h want 1/a5", bytes_sent, tx_data);
    end
  endtask

  task automatic test_fill();
    logic [7:0] b;
    bit ok;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      @(negedge tx_clk);
    end
    n_tests++;
    if (full !== 1'b1 || level !== LW'(16)) begin
      n_fail++;
      $display("FAIL fill_full: full=%b level=%0d want 1/16", full, level);
    end
    wr_data = 8'hEE;
    @(negedge tx_clk);
    wr_en = 1'b0;
    n_tests++;
    if (full !== 1'b1 || level !== LW'(16)) begin
      n_fail++;
      $display("FAIL fill_drop: full=%b level=%0d want 1/16", full, level);
    end
    for (int i = 1; i <= 16; i++) begin
      serve_one(b, ok);
      n_tests++;
      if (!ok || b !== 8'(i)) begin
        n_fail++;
        $display("FAIL fill_order: idx=%0d ok=%b got %h want %h", i, ok, b, 8'(i));
      end
    end
    repeat (6) @(negedge tx_clk);
    n_tests++;
    if (bytes_sent !== 16'd16 || empty !== 1'b1 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_done: sent=%0d empty=%b start=%b want 16/1/0",
               bytes_sent, empty, tx_start);
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] q[$];
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      wr_byte(b);
    end
    wr_en = 1'b1;
    wr_data = 8'h5A;
    tx_ready = 1'b1;
    @(negedge tx_clk);
    wr_en = 1'b0;
    q.push_back(8'h5A);
    n_tests++;
    if (level !== LW'(16) || full !== 1'b1 || tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_level: level=%0d full=%b start=%b want 16/1/1",
               level, full, tx_start);
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      serve_one(b, ok);
      e = q.pop_front();
      n_tests++;
      if (!ok || b !== e) begin
        n_fail++;
        $display("FAIL simul_order: idx=%0d ok=%b got %h want %h", i, ok, b, e);
      end
    end
    repeat (6) @(negedge tx_clk);
    n_tests++;
    if (bytes_sent !== 16'd17 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_count: sent=%0d empty=%b want 17/1", bytes_sent, empty);
    end
  endtask

  task automatic test_reset_busy();
    bit seen;
    do_reset();
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    wr_byte(8'h44);
    tx_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge tx_clk);
      seen = tx_start;
    end
    tx_ready = 1'b0;
    @(negedge tx_clk);
    n_tests++;
    if (!seen || tx_start !== 1'b0 || level !== LW'(3)) begin
      n_fail++;
      $display("FAIL rstbusy_setup: seen=%b start=%b level=%0d want 1/0/3",
               seen, tx_start, level);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({empty, tx_start, bytes_sent, level} !== {1'b1, 1'b0, 16'h0, LW'(0)}) begin
      n_fail++;
      $display("FAIL rstbusy_now: empty=%b start=%b sent=%0d level=%0d",
               empty, tx_start, bytes_sent, level);
    end
    @(negedge tx_clk);
    reset = 1'b0;
    tx_ready = 1'b1;
    repeat (10) @(negedge tx_clk);
    n_tests++;
    if (tx_start !== 1'b0 || bytes_sent !== 16'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rstbusy_after: start=%b sent=%0d empty=%b want 0/0/1",
               tx_start, bytes_sent, empty);
    end
  endtask

  task automatic test_wdog();
    int cnt;
    logic [7:0] b;
    bit ok;
    do_reset();
    tx_ready = 1'b1;
    wr_byte(8'h77);
    @(negedge tx_clk);
    cnt = 0;
    while (tx_start && cnt < 40) begin
      cnt++;
      @(negedge tx_clk);
    end
`ifdef TX_FEEDER_WDOG_EN
    n_tests++;
    if (cnt != 16 || tx_start !== 1'b0 || wdog_err !== 1'b1 ||
        bytes_sent !== 16'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_trip: cycles=%0d start=%b err=%b sent=%0d want 16/0/1/0",
               cnt, tx_start, wdog_err, bytes_sent);
    end
    wr_byte(8'h78);
    serve_one(b, ok);
    repeat (4) @(negedge tx_clk);
    n_tests++;
    if (!ok || b !== 8'h78 || wdog_err !== 1'b1 || bytes_sent !== 16'd1) begin
      n_fail++;
      $display("FAIL wdog_sticky: ok=%b byte=%h err=%b sent=%0d want 1/78/1/1",
               ok, b, wdog_err, bytes_sent);
    end
`else
    n_tests++;
    if (cnt != 40 || tx_start !== 1'b1 || bytes_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL nowdog_wait: cycles=%0d start=%b sent=%0d want 40/1/0",
               cnt, tx_start, bytes_sent);
    end
    serve_one(b, ok);
    repeat (4) @(negedge tx_clk);
    n_tests++;
    if (!ok || b !== 8'h77 || bytes_sent !== 16'd1) begin
      n_fail++;
      $display("FAIL nowdog_finish: ok=%b byte=%h sent=%0d want 1/77/1",
               ok, b, bytes_sent);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    bit ok;
    do_reset();
    force dut.r_bytes_sent = 16'hFFFF;
    #1 release dut.r_bytes_sent;
    n_tests++;
    if (bytes_sent !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h want ffff", bytes_sent);
    end
    wr_byte(8'h3C);
    serve_one(b, ok);
    repeat (4) @(negedge tx_clk);
    n_tests++;
    if (!ok || b !== 8'h3C || bytes_sent !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_count: ok=%b byte=%h sent=%h want 1/3c/0000",
               ok, b, bytes_sent);
    end
  endtask

  task automatic test_random(input int ncyc);
    logic [7:0] q[$];
    logic [7:0] held;
    logic [7:0] e;
    logic [7:0] pb;
    bit prev_start;
    bit pend;
    int xs;
    int dly;
    int popped;
    do_reset();
    tx_ready = 1'b1;
    prev_start = 1'b0;
    pend = 1'b0;
    xs = 0;
    dly = 0;
    popped = 0;
    held = 8'h00;
    pb = 8'h00;
    for (int c = 0; c < ncyc + 400; c++) begin
      @(negedge tx_clk);
      if (tx_start && !prev_start) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_pop: cycle=%0d got %h want nothing", c, tx_data);
        end else begin
          e = q.pop_front();
          if (tx_data !== e) begin
            n_fail++;
            $display("FAIL rnd_order: cycle=%0d got %h want %h", c, tx_data, e);
          end
        end
        popped++;
        held = tx_data;
      end else if (tx_start) begin
        n_tests++;
        if (tx_data !== held) begin
          n_fail++;
          $display("FAIL rnd_stable: cycle=%0d got %h want %h", c, tx_data, held);
        end
      end
      if (pend) q.push_back(pb);
      n_tests++;
      if ({full, empty, level} !==
          {q.size() == DEPTH, q.size() == 0, LW'(q.size())}) begin
        n_fail++;
        $display("FAIL rnd_flags: cycle=%0d full=%b empty=%b level=%0d want level %0d",
                 c, full, empty, level, q.size());
      end
      prev_start = tx_start;
      case (xs)
        0: if (tx_start && tx_ready) begin
          dly = $urandom_range(0, 3);
          if (dly == 0) begin
            tx_ready = 1'b0;
            dly = $urandom_range(1, 4);
            xs = 2;
          end else begin
            xs = 1;
          end
        end
        1: begin
          dly--;
          if (dly == 0) begin
            tx_ready = 1'b0;
            dly = $urandom_range(1, 4);
            xs = 2;
          end
        end
        default: begin
          dly--;
          if (dly == 0) begin
            tx_ready = 1'b1;
            xs = 0;
          end
        end
      endcase
      if (c < ncyc && q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        pb = wr_data;
        pend = 1'b1;
      end else begin
        wr_en = 1'b0;
        pend = 1'b0;
      end
    end
    n_tests++;
    if (q.size() != 0 || tx_start !== 1'b0 || bytes_sent !== 16'(popped)) begin
      n_fail++;
      $display("FAIL rnd_drain: left=%0d start=%b sent=%0d want 0/0/%0d",
               q.size(), tx_start, bytes_sent, popped);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_reset_busy();
    test_wdog();
    test_wrap();
    test_random(2000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
